// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: registers the four write-back candidates and control, waits for multi-cycle loads.
// Optional retired-instruction counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH      = 32
`endif
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic [DATA_WIDTH-1:0]     in_mem_rdata,
    input  logic [DATA_WIDTH-1:0]     in_link_addr,
    input  logic [DATA_WIDTH-1:0]     in_imm_upper,
    input  logic [1:0]                in_wb_sel,
    input  logic                      in_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] in_dest_reg,
    input  logic                      in_is_load,
    input  logic                      mem_ready,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_alu_result,
    output logic [DATA_WIDTH-1:0]     out_mem_rdata,
    output logic [DATA_WIDTH-1:0]     out_link_addr,
    output logic [DATA_WIDTH-1:0]     out_imm_upper,
    output logic [1:0]                out_wb_sel,
    output logic                      out_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] out_dest_reg,
    output logic                      stall_out
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      retire_count
`endif
);

    typedef enum logic {
        RUN,
        WAIT_MEM
    } state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     holdAlu;
    logic [DATA_WIDTH-1:0]     holdLink;
    logic [DATA_WIDTH-1:0]     holdImm;
    logic [1:0]                holdSel;
    logic                      holdRegWrite;
    logic [REG_ADDR_WIDTH-1:0] holdDest;

    logic captureLoad;
    logic retire;

    // A load entering without its data parks in the hold registers instead of the outputs.
    assign captureLoad = (state == RUN) && in_valid && in_is_load && !mem_ready && !flush;

    assign retire = !flush &&
                    (((state == RUN) && in_valid && !(in_is_load && !mem_ready)) ||
                     ((state == WAIT_MEM) && mem_ready));

    // Gated by reset so upstream never sees a stall while the pipeline is held in reset.
    assign stall_out = Reset_n &&
                       (((state == WAIT_MEM) && !flush && !mem_ready) || captureLoad);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= RUN;
            holdAlu        <= '0;
            holdLink       <= '0;
            holdImm        <= '0;
            holdSel        <= '0;
            holdRegWrite   <= 1'b0;
            holdDest       <= '0;
            out_valid      <= 1'b0;
            out_alu_result <= '0;
            out_mem_rdata  <= '0;
            out_link_addr  <= '0;
            out_imm_upper  <= '0;
            out_wb_sel     <= '0;
            out_reg_write  <= 1'b0;
            out_dest_reg   <= '0;
        end else begin
            out_valid     <= retire;
            out_reg_write <= 1'b0;
            case (state)
                RUN: begin
                    if (captureLoad) begin
                        holdAlu      <= in_alu_result;
                        holdLink     <= in_link_addr;
                        holdImm      <= in_imm_upper;
                        holdSel      <= in_wb_sel;
                        holdRegWrite <= in_reg_write;
                        holdDest     <= in_dest_reg;
                        state        <= WAIT_MEM;
                    end else begin
                        out_alu_result <= in_alu_result;
                        out_mem_rdata  <= in_mem_rdata;
                        out_link_addr  <= in_link_addr;
                        out_imm_upper  <= in_imm_upper;
                        out_wb_sel     <= in_wb_sel;
                        out_dest_reg   <= in_dest_reg;
                        out_reg_write  <= retire && in_reg_write && (in_dest_reg != '0);
                    end
                end
                WAIT_MEM: begin
                    if (flush) begin
                        state <= RUN;
                    end else if (mem_ready) begin
                        out_alu_result <= holdAlu;
                        out_mem_rdata  <= in_mem_rdata;
                        out_link_addr  <= holdLink;
                        out_imm_upper  <= holdImm;
                        out_wb_sel     <= holdSel;
                        out_dest_reg   <= holdDest;
                        out_reg_write  <= holdRegWrite && (holdDest != '0);
                        state          <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (retire counter checks active when MEM_WB_RETIRE_CNT_EN is defined).
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        in_valid;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_link_addr;
    logic [31:0] in_imm_upper;
    logic [1:0]  in_wb_sel;
    logic        in_reg_write;
    logic [4:0]  in_dest_reg;
    logic        in_is_load;
    logic        mem_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_alu_result;
    logic [31:0] out_mem_rdata;
    logic [31:0] out_link_addr;
    logic [31:0] out_imm_upper;
    logic [1:0]  out_wb_sel;
    logic        out_reg_write;
    logic [4:0]  out_dest_reg;
    logic        stall_out;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [3:0]  retire_count;
`endif

    int unsigned nAsserts = 0;
    int unsigned nFails   = 0;

    always #5 Clk = ~Clk;

    mem_wb_stage #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .CNT_WIDTH     (4)
`endif
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .in_valid      (in_valid),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_link_addr  (in_link_addr),
        .in_imm_upper  (in_imm_upper),
        .in_wb_sel     (in_wb_sel),
        .in_reg_write  (in_reg_write),
        .in_dest_reg   (in_dest_reg),
        .in_is_load    (in_is_load),
        .mem_ready     (mem_ready),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_alu_result(out_alu_result),
        .out_mem_rdata (out_mem_rdata),
        .out_link_addr (out_link_addr),
        .out_imm_upper (out_imm_upper),
        .out_wb_sel    (out_wb_sel),
        .out_reg_write (out_reg_write),
        .out_dest_reg  (out_dest_reg),
        .stall_out     (stall_out)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction; the clock edge is taken by the caller.
    task automatic drive(input logic v, input logic ld, input logic rdy, input logic fl,
                         input logic [1:0] sel, input logic rw, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [31:0] rdata);
        in_valid      = v;
        in_is_load    = ld;
        mem_ready     = rdy;
        flush         = fl;
        in_wb_sel     = sel;
        in_reg_write  = rw;
        in_dest_reg   = dest;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n       = 1'b0;
        in_valid      = 1'b1;
        in_is_load    = 1'b1;
        mem_ready     = 1'b0;
        flush         = 1'b0;
        in_alu_result = $urandom;
        in_mem_rdata  = $urandom;
        in_link_addr  = $urandom;
        in_imm_upper  = $urandom;
        in_wb_sel     = 2'($urandom_range(3));
        in_reg_write  = 1'b1;
        in_dest_reg   = 5'($urandom_range(31));
        tick();
        tick();
        check("reset_valid", out_valid, 0);
        check("reset_regw", out_reg_write, 0);
        check("reset_alu", out_alu_result, 0);
        check("reset_rdata", out_mem_rdata, 0);
        check("reset_dest", out_dest_reg, 0);
        check("reset_stall", stall_out, 0);
`ifdef MEM_WB_RETIRE_CNT_EN
        check("reset_cnt", retire_count, 0);
`endif

        // First ALU op after reset release
        Reset_n      = 1'b1;
        in_link_addr = 32'h0040_0008;
        in_imm_upper = 32'h1234_0000;
        drive(1, 0, 0, 0, 2'd0, 1, 5'd3, 32'h0000_0005, 32'h0);
        #1;
        check("alu_stall", stall_out, 0);
        tick();
        check("alu_valid", out_valid, 1);
        check("alu_result", out_alu_result, 32'h0000_0005);
        check("alu_sel", out_wb_sel, 0);
        check("alu_dest", out_dest_reg, 3);
        check("alu_regw", out_reg_write, 1);

        // Multi-cycle load, memory ready after 3 stalled cycles
        drive(1, 1, 0, 0, 2'd1, 1, 5'd8, 32'h0000_0A0A, 32'h0);
        #1;
        check("ld_stall0", stall_out, 1);
        tick();
        check("ld_wait0_valid", out_valid, 0);
        drive(1, 0, 0, 0, 2'd3, 0, 5'd31, 32'hFFFF_FFFF, 32'h0);
        #1;
        check("ld_stall1", stall_out, 1);
        tick();
        check("ld_wait1_valid", out_valid, 0);
        #1;
        check("ld_stall2", stall_out, 1);
        tick();
        check("ld_wait2_valid", out_valid, 0);
        mem_ready    = 1'b1;
        in_mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_stall3", stall_out, 0);
        tick();
        check("ld_valid", out_valid, 1);
        check("ld_rdata", out_mem_rdata, 32'hDEAD_BEEF);
        check("ld_dest", out_dest_reg, 8);
        check("ld_sel", out_wb_sel, 1);
        check("ld_alu_held", out_alu_result, 32'h0000_0A0A);
        check("ld_regw", out_reg_write, 1);

        // Flush wins over mem_ready while waiting
        drive(1, 1, 0, 0, 2'd1, 1, 5'd9, 32'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        mem_ready    = 1'b1;
        flush        = 1'b1;
        in_mem_rdata = 32'h5555_AAAA;
        #1;
        check("flw_stall", stall_out, 0);
        tick();
        check("flw_valid", out_valid, 0);
        check("flw_regw", out_reg_write, 0);
        drive(1, 0, 0, 0, 2'd0, 1, 5'd4, 32'h0000_0077, 32'h0);
        #1;
        check("flw_run_stall", stall_out, 0);
        tick();
        check("flw_run_valid", out_valid, 1);
        check("flw_run_alu", out_alu_result, 32'h0000_0077);

        // Register 0 write suppressed
        drive(1, 0, 0, 0, 2'd0, 1, 5'd0, 32'h0000_0123, 32'h0);
        tick();
        check("r0_valid", out_valid, 1);
        check("r0_regw", out_reg_write, 0);

        // Four back-to-back loads with data ready
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1, 1, 1, 0, 2'(i), 1, 5'(10 + i), 32'h100 + i, 32'h200 + i);
            #1;
            check("st_stall", stall_out, 0);
            tick();
            check("st_valid", out_valid, 1);
            check("st_sel", out_wb_sel, i);
            check("st_rdata", out_mem_rdata, 32'h200 + i);
            check("st_dest", out_dest_reg, 10 + i);
            check("st_link", out_link_addr, 32'h0040_0008);
            check("st_imm", out_imm_upper, 32'h1234_0000);
        end

        // Flush in RUN, then a bubble
        drive(1, 0, 0, 1, 2'd0, 1, 5'd5, 32'h9, 32'h0);
        tick();
        check("flr_valid", out_valid, 0);
        check("flr_regw", out_reg_write, 0);
        drive(0, 0, 0, 0, 2'd0, 1, 5'd5, 32'h9, 32'h0);
        tick();
        check("bub_valid", out_valid, 0);
        check("bub_regw", out_reg_write, 0);

`ifdef MEM_WB_RETIRE_CNT_EN
        check("cnt_eight", retire_count, 8);
        for (int unsigned i = 0; i < 7; i++) begin
            drive(1, 0, 0, 0, 2'd0, 1, 5'd6, 32'(i), 32'h0);
            tick();
        end
        check("cnt_fifteen", retire_count, 15);
        drive(1, 0, 0, 0, 2'd0, 1, 5'd6, 32'h1, 32'h0);
        tick();
        check("cnt_wrap", retire_count, 0);
`endif

        // Reset asserted mid-wait abandons the load
        drive(1, 1, 0, 0, 2'd1, 1, 5'd7, 32'h0, 32'h0);
        tick();
        Reset_n = 1'b0;
        #1;
        check("rstw_stall", stall_out, 0);
        Reset_n = 1'b1;
        drive(0, 0, 1, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        check("rstw_run_stall", stall_out, 0);
        tick();
        check("rstw_valid", out_valid, 0);
        check("rstw_regw", out_reg_write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the MEM stage and the write-back 4:1 data mux.
- Captures the four write-back data candidates plus the 2-bit write-back select, destination register and write enable, and presents them registered to the write-back mux and register file.
- Handles multi-cycle data-memory loads with a ready handshake and a stall back to the earlier stages.
- Supports flush (bubble insertion) from hazard control.

Parameters:
DATA_WIDTH, 32, width of every data candidate
REG_ADDR_WIDTH, 5, register-file address width
CNT_WIDTH, 32, width of the retired-instruction counter (optional feature only)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  MEM stage holds a real instruction
in_alu_result  input  DATA_WIDTH  ALU result (wb_sel 0)
in_mem_rdata  input  DATA_WIDTH  data-memory read data (wb_sel 1)
in_link_addr  input  DATA_WIDTH  PC+8 link address (wb_sel 2)
in_imm_upper  input  DATA_WIDTH  LUI immediate << 16 (wb_sel 3)
in_wb_sel  input  2  write-back source select
in_reg_write  input  1  instruction writes the register file
in_dest_reg  input  REG_ADDR_WIDTH  destination register
in_is_load  input  1  instruction is a load and needs mem_ready
mem_ready  input  1  in_mem_rdata is valid this cycle
flush  input  1  kill the instruction currently entering or waiting
out_valid  output  1  registered instruction is real
out_alu_result, out_mem_rdata, out_link_addr, out_imm_upper  output  DATA_WIDTH each  registered candidates to the write-back mux
out_wb_sel  output  2  registered select to the write-back mux
out_reg_write  output  1  register-file write enable
out_dest_reg  output  REG_ADDR_WIDTH  register-file write address
stall_out  output  1  combinational; upstream must hold its stage registers

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - All outputs and hold registers are 0; state=RUN; out_valid=0; out_reg_write=0.
  - Reset asserted mid-WAIT_MEM abandons the load with no write.
- Latency: 1 cycle from an accepted input to the registered outputs.
- State RUN:
  - flush=1: next out_valid=0 and out_reg_write=0. Data registers may load, but are don't-care.
  - in_valid=1 and in_is_load=1 and mem_ready=0 and flush=0:
    - Capture all inputs except mem_rdata into hold registers.
    - Next out_valid=0 (bubble); go to WAIT_MEM.
  - Otherwise: load all out_* from the inputs; out_valid<=in_valid.
- State WAIT_MEM:
  - flush=1 (priority over mem_ready): go to RUN; out_valid=0; the held instruction is discarded.
  - mem_ready=1: load outputs from the hold registers plus in_mem_rdata; out_valid=1; go to RUN.
  - mem_ready=0: stay in WAIT_MEM; outputs remain a bubble.
- stall_out = (state==WAIT_MEM and not flush and not mem_ready) or (state==RUN and in_valid and in_is_load and not mem_ready and not flush).
- While stall_out=1, the inputs other than in_mem_rdata, mem_ready and flush are ignored.
- out_reg_write = registered (valid and reg_write and dest_reg!=0). Writes to register 0 are always suppressed.
- Non-load instructions never wait; mem_ready is ignored for them.
- Back-to-back loads with mem_ready=1 stream at one per cycle.
- out_wb_sel is passed through unmodified; all four values are legal.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN
- Defined:
  - Adds output retire_count [CNT_WIDTH-1:0], reset to 0.
  - Increments by 1 on every cycle in which out_valid becomes 1 (an instruction is registered as valid).
  - Wraps from all-ones to 0.
  - Flushed instructions and bubbles are not counted.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold Reset_n=0 with random inputs -> all outputs 0 and stall_out=0; release -> first valid ALU op (alu=0x00000005, sel=0, dest=3) appears next cycle with out_reg_write=1.
- Multi-cycle load:
  - Stimulus: load with dest=8, sel=1, mem_ready low for 3 cycles, then high with rdata=0xDEADBEEF.
  - Required: stall_out=1 for exactly 3 cycles; out_valid=0 during the wait; then out_valid=1, out_mem_rdata=0xDEADBEEF, out_dest_reg=8.
- Flush in WAIT_MEM: flush=1 on the 2nd wait cycle together with mem_ready=1 -> out_valid=0, out_reg_write=0, state back to RUN, stall_out=0 in that cycle.
- Register-0 suppression: valid op with reg_write=1, dest=0 -> out_valid=1, out_reg_write=0.
- Streaming: 4 consecutive loads with mem_ready=1 and sel=0..3 cycling (link=0x00400008, imm=0x12340000) -> 4 valid outputs on consecutive cycles, correct out_wb_sel each cycle, stall_out never 1.
- MEM_WB_RETIRE_CNT_EN:
  - 10 valid ops, 2 flushed and 1 bubble -> retire_count=8.
  - Preload near wrap (CNT_WIDTH=4, 15 retired) plus one more -> retire_count=0.
